io_addr_decode_sync: RTL

Parametrised, registered I/O address decoder for the processor port bus. It turns a processor READ/WRITE strobe plus a port address into a one-hot read or write select for a peripheral register. It generalises the fixed 4-bank x 16-line decode to 2^BANK_W banks x 2^SEL_W lines. New behaviour over the combinational decoder:
- registered outputs with a programmable strobe width
- a single select per request, with re-arm only after the request drops
- a sticky read/write collision flag

---
 rtl/io_addr_decode_sync.sv | 128 ++++++++++++
 1 files changed

// File: rtl/io_addr_decode_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_addr_decode_sync: registered one-hot port-bus read/write select decoder |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module io_addr_decode_sync #(
  parameter  int unsigned BANK_W = 2,
  parameter  int unsigned SEL_W  = 4,
  parameter  int unsigned HOLD   = 1,
  localparam int unsigned AW     = BANK_W + SEL_W,
  localparam int unsigned N      = 1 << AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ADDR,
  input  logic          READ,
  input  logic          WRITE,
  output logic [N-1:0]  READS,
  output logic [N-1:0]  WRITES,
  output logic          BUSY,
  output logic          ERR
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STROBE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0]   HOLD_CNT = 8'(HOLD);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [7:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic [N-1:0]    reads_q;
  logic [N-1:0]    writes_q;
  logic            busy_q;
  logic            err_q;

  logic [N-1:0]    w_addr_sel;
  logic [N-1:0]    w_latched_sel;

  assign w_addr_sel    = ONE_HOT0 << ADDR;
  assign w_latched_sel = ONE_HOT0 << addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      reads_q  <= '0;
      writes_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (READ ^ WRITE) begin
            addr_q   <= ADDR;
            wr_q     <= WRITE;
            cnt_q    <= HOLD_CNT;
            state_q  <= ST_STROBE;
            busy_q   <= 1'b1;
            reads_q  <= WRITE ? '0 : w_addr_sel;
            writes_q <= WRITE ? w_addr_sel : '0;
          end else if (READ && WRITE) begin
            // Ambiguous request: flag it and wait for both strobes to drop.
            err_q    <= 1'b1;
            state_q  <= ST_RELEASE;
            busy_q   <= 1'b1;
            reads_q  <= '0;
            writes_q <= '0;
          end else begin
            reads_q  <= '0;
            writes_q <= '0;
            busy_q   <= 1'b0;
          end
        end

        ST_STROBE: begin
          if (cnt_q <= 8'd1) begin
            cnt_q    <= 8'd0;
            reads_q  <= '0;
            writes_q <= '0;
            // A still-asserted level request must not retrigger a second select.
            if (READ || WRITE) begin
              state_q <= ST_RELEASE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q    <= cnt_q - 8'd1;
            reads_q  <= wr_q ? '0 : w_latched_sel;
            writes_q <= wr_q ? w_latched_sel : '0;
          end
        end

        ST_RELEASE: begin
          reads_q  <= '0;
          writes_q <= '0;
          if (!READ && !WRITE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          reads_q  <= '0;
          writes_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign READS  = reads_q;
  assign WRITES = writes_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;

endmodule
`default_nettype wire
